// File: rtl/axis_video_pkg.sv
// axis_video_pkg: shared constants and beat type for the 8-bit AXI-Stream video blocks
package axis_video_pkg;
  localparam int DEF_DATA_W = 8;
  localparam int FC_W = 16;
  localparam int DEF_WIDTH = 240;
  localparam int DEF_HEIGHT = 200;
  typedef struct packed {
    logic [DEF_DATA_W-1:0] data;
    logic user;
    logic last;
    logic eof;
  } beat_t;
endpackage

// File: rtl/axis_skid_buffer.sv
// axis_skid_buffer: two-entry buffer with registered ready, so downstream stalls never reach the source combinationally
module axis_skid_buffer
  import axis_video_pkg::*;
#(
  parameter type T = beat_t
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  output logic in_ready,
  input  T     in_beat,
  output logic out_valid,
  input  logic out_ready,
  output T     out_beat
);
  T skid;
  logic skid_valid, load_out, accept, skid_next;
  assign accept = in_valid && in_ready;
  assign load_out = !out_valid || out_ready;
  assign skid_next = load_out ? 1'b0 : skid_valid || accept;
  always_ff @(posedge clk)
    if (rst) begin
      in_ready <= 1'b0;
      skid_valid <= 1'b0;
      skid <= '0;
      out_valid <= 1'b0;
      out_beat <= '0;
    end else begin
      in_ready <= !skid_next;
      skid_valid <= skid_next;
      if (!load_out && accept) skid <= in_beat;
      if (load_out) out_valid <= skid_valid || accept;
      if (load_out && (skid_valid || accept)) out_beat <= skid_valid ? skid : in_beat;
    end
endmodule

// File: rtl/axis_frame_source.sv
// axis_frame_source: frames a raw pixel stream as AXI-Stream video (tUser=SOF, tLast=EOL); TEST_PATTERN_EN adds a gradient generator
module axis_frame_source
  import axis_video_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int HEIGHT = DEF_HEIGHT,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] Pix_In_Data,
  input  logic              Pix_In_Valid,
  output logic              Pix_In_Ready,
  input  logic              pattern_mode,
  output logic [DATA_W-1:0] AXIS_Out_tData,
  output logic              AXIS_Out_tValid,
  input  logic              AXIS_Out_tReady,
  output logic              AXIS_Out_tUser,
  output logic              AXIS_Out_tLast,
  output logic              frame_done,
  output logic [FC_W-1:0]   frame_count
);
  localparam int CW = $clog2(WIDTH);
  localparam int RW = HEIGHT > 1 ? $clog2(HEIGHT) : 1;
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic user;
    logic last;
    logic eof;
  } pix_beat_t;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic src_valid, src_ready, accept, at_origin, at_col_end, at_row_end, fire_eof;
  logic [DATA_W-1:0] src_data;
  pix_beat_t in_beat, out_beat;
  assign at_origin = col == '0 && row == '0;
  assign at_col_end = col == CW'(WIDTH - 1);
  assign at_row_end = row == RW'(HEIGHT - 1);
`ifdef TEST_PATTERN_EN
  logic mode_q, mode;
  assign mode = at_origin ? pattern_mode : mode_q;
  assign src_valid = mode ? 1'b1 : Pix_In_Valid;
  assign src_data = mode ? DATA_W'(32'(col) + 32'(row)) : Pix_In_Data;
  assign Pix_In_Ready = src_ready && !mode;
  always_ff @(posedge clk) mode_q <= reset ? 1'b0 : mode;
`else
  logic unused_pattern;
  assign unused_pattern = pattern_mode;
  assign src_valid = Pix_In_Valid;
  assign src_data = Pix_In_Data;
  assign Pix_In_Ready = src_ready;
`endif
  assign accept = src_valid && src_ready;
  assign in_beat = '{data: src_data, user: at_origin, last: at_col_end, eof: at_col_end && at_row_end};
  axis_skid_buffer #(.T(pix_beat_t)) u_skid (
    .clk(clk),
    .rst(reset),
    .in_valid(src_valid),
    .in_ready(src_ready),
    .in_beat(in_beat),
    .out_valid(AXIS_Out_tValid),
    .out_ready(AXIS_Out_tReady),
    .out_beat(out_beat)
  );
  assign AXIS_Out_tData = out_beat.data;
  assign AXIS_Out_tUser = out_beat.user;
  assign AXIS_Out_tLast = out_beat.last;
  assign fire_eof = AXIS_Out_tValid && AXIS_Out_tReady && out_beat.last && out_beat.eof;
  always_ff @(posedge clk)
    if (reset) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      col <= at_col_end ? '0 : col + 1'b1;
      row <= at_col_end ? (at_row_end ? '0 : row + 1'b1) : row;
    end
  always_ff @(posedge clk)
    if (reset) begin
      frame_done <= 1'b0;
      frame_count <= '0;
    end else begin
      frame_done <= fire_eof;
      frame_count <= frame_count + FC_W'(fire_eof);
    end
endmodule
